// File: rtl/mem_copy_engine.sv
// Word-granular memory-to-memory copy engine.
// Reads port A one word per cycle and writes port B one cycle later.
module mem_copy_engine #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 49152
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcBase,
    input  logic [ADDR_W-1:0] dstBase,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] memOut,
    output logic [ADDR_W-1:0] addressB,
    output logic [DATA_W-1:0] inputDataB,
    output logic              writeEnableB,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] wordCount
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t state, state_nx;

    logic [ADDR_W-1:0] src, dst, len;
    logic [ADDR_W-1:0] rd_idx, wr_idx, count;
    logic              wr_vld, err_q;
    logic [ADDR_W:0]   src_end, dst_end;
    logic              range_bad, overlap, req, accept, last_rd;

    // End addresses are one bit wider so a wrap cannot hide an overrun
    assign src_end   = {1'b0, srcBase} + {1'b0, length};
    assign dst_end   = {1'b0, dstBase} + {1'b0, length};
    assign range_bad = (src_end > DEPTH) || (dst_end > DEPTH);
    assign overlap   = (dstBase > srcBase) && ({1'b0, dstBase} < src_end);
    assign req       = (state == IDLE) && start;
    assign accept    = req && !range_bad && !overlap;
    assign last_rd   = (rd_idx == len - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = (length == '0) ? FIN : READ;
            READ:  if (last_rd) state_nx = DRAIN;
            DRAIN: state_nx = FIN;
            FIN:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
            wr_vld <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= req && (range_bad || overlap);
            // A read issued this cycle becomes a write next cycle
            wr_vld <= (state == READ);
            wr_idx <= (state == READ) ? rd_idx : '0;
            if (accept) begin
                src    <= srcBase;
                dst    <= dstBase;
                len    <= length;
                rd_idx <= '0;
                count  <= '0;
            end else begin
                if (state == READ) rd_idx <= rd_idx + 1'b1;
                if (wr_vld)        count  <= count + 1'b1;
            end
        end
    end

    assign address      = (state == READ) ? src + rd_idx : '0;
    assign addressB     = wr_vld ? dst + wr_idx : '0;
    assign inputDataB   = wr_vld ? memOut : '0;
    assign writeEnableB = wr_vld;
    assign busy         = (state == READ) || (state == DRAIN);
    assign done         = (state == FIN);
    assign error        = err_q;
    assign wordCount    = count;

endmodule
